tds_channel_readout_merger: RTL and testbench

- Parametrised N-channel readout merger that sits after the per-channel strip/pad decoders, in the clk160 readout domain.
- Arbitrates round-robin across per-channel first-word-fall-through (FWFT) channel FIFOs and pops their words in bounded bursts.
- Emits one tagged valid/ready stream toward the readout/Ethernet packer, and keeps per-channel word statistics.
- Generalises the fixed 4-channel, per-channel-read arrangement to any channel count, with burst fairness, a stop control and backpressure.

---
 rtl/tds_readout_pkg.sv | 39 +++
 rtl/tds_channel_readout_merger_rr_arbiter.sv | 27 ++
 rtl/tds_channel_readout_merger.sv | 160 ++++++++++++++++
 tb/tb_tds_channel_readout_merger.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tds_readout_pkg.sv
// Shared definitions for the TDS readout merger.
// Contents:
//   TDS_DATA_W / TDS_CH_W - default channel word and channel-tag widths
//   state_t               - merger FSM states (IDLE, BURST, DRAIN)
//   rr_next()             - round-robin search: first set request strictly
//                           after ptr, modulo n; returns {found, index}
package tds_readout_pkg;

   localparam int TDS_DATA_W = 120;
   localparam int TDS_CH_W   = 4;
   localparam int RR_MAX_CH  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Scans ptr+1, ptr+2, ... modulo n. Because the scan visits RR_MAX_CH
   // positions, indices repeat when n < RR_MAX_CH. The found bit stops any
   // later hit from overwriting the first one, so the repeats do no harm.
   function automatic logic [4:0] rr_next(input logic [15:0] req,
                                          input logic [3:0]  ptr,
                                          input int          n);
      logic [4:0] res;
      logic [3:0] idx4;
      int         idx;
      res = '0;
      if (n > 0) begin
         for (int k = 1; k <= RR_MAX_CH; k++) begin
            idx  = (int'(ptr) + k) % n;
            idx4 = 4'(idx);
            if (!res[4] && req[idx4]) res = {1'b1, idx4};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/tds_channel_readout_merger_rr_arbiter.sv
// Combinational round-robin arbiter. The merger uses it for channel
// selection, and it can also serve the pad-channel merging.
// Ports:
//   req      in  NUM_CH  request vector
//   ptr      in  CH_W    last-served index; the search starts at ptr+1
//   gnt_idx  out CH_W    granted index (valid only with gnt_vld)
//   gnt_vld  out 1       at least one request is set
module rr_arbiter
   import tds_readout_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 4
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   ptr,
   output logic [CH_W-1:0]   gnt_idx,
   output logic              gnt_vld
);

   logic [4:0] res;

   always_comb res = rr_next(16'(req), 4'(ptr), NUM_CH);

   assign gnt_vld = res[4];
   assign gnt_idx = CH_W'(res[3:0]);

endmodule

// File: rtl/tds_channel_readout_merger.sv
// Merges NUM_CH FWFT channel FIFOs into a single tagged valid/ready stream.
// Channels are granted round-robin, and each grant pops up to MAX_BURST words.
// The block also keeps per-channel counters of the words it has transferred.
// Ports:
//   clk160, reset            clock, async active-high reset
//   enable, tds_mode         channel enable mask; 1 = strip, 0 = pad links
//   strip_linked, pad_linked decoder link status
//   channel_linked           selected link status (combinational)
//   data_tran_stop           no new grants; the current burst closes
//   ch_data, ch_empty        FIFO heads (channel 0 in the LSBs) and empty flags
//   ch_read                  one-hot pop strobes (combinational)
//   out_data/ch/last/valid   merged output stream, out_ready = downstream accept
//   busy                     FSM not in IDLE
//   word_count               per-channel transferred-word counters
module tds_channel_readout_merger
   import tds_readout_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int DATA_W    = TDS_DATA_W,
   parameter int CH_W      = TDS_CH_W,
   parameter int MAX_BURST = 16,
   parameter int STAT_W    = 32
) (
   input  logic                     clk160,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        enable,
   input  logic                     tds_mode,
   input  logic [NUM_CH-1:0]        strip_linked,
   input  logic [NUM_CH-1:0]        pad_linked,
   output logic [NUM_CH-1:0]        channel_linked,
   input  logic                     data_tran_stop,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic [NUM_CH-1:0]        ch_empty,
   output logic [NUM_CH-1:0]        ch_read,
   output logic [DATA_W-1:0]        out_data,
   output logic [CH_W-1:0]          out_ch,
   output logic                     out_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     busy,
   output logic [NUM_CH*STAT_W-1:0] word_count
);

   state_t                         state;
   logic [CH_W-1:0]                ptr, g, gnt_idx;
   logic                           gnt_vld;
   logic [7:0]                     bc;
   logic [8:0]                     bc_inc;
   logic [NUM_CH-1:0]              elig;
   logic                           slot_free, pop, last_beat;
   logic [DATA_W-1:0]              sel_data;
   logic                           sel_empty, sel_ok;
   logic [NUM_CH-1:0][STAT_W-1:0]  cnt;

   assign channel_linked = tds_mode ? strip_linked : pad_linked;
   assign elig           = enable & channel_linked & ~ch_empty;

   rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
      .req     (elig),
      .ptr     (ptr),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   // Comparison mux over the granted channel. An explicit compare avoids
   // indexing NUM_CH-wide vectors with a CH_W-wide index.
   always_comb begin
      sel_data  = '0;
      sel_empty = 1'b1;
      sel_ok    = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (g == CH_W'(i)) begin
            sel_data  = ch_data[i*DATA_W +: DATA_W];
            sel_empty = ch_empty[i];
            sel_ok    = enable[i] & channel_linked[i];
         end
      end
   end

   assign slot_free = ~out_valid | out_ready;
   assign pop       = (state == BURST) & slot_free & ~sel_empty & sel_ok;
   assign bc_inc    = {1'b0, bc} + 9'd1;
   assign last_beat = (bc_inc == 9'(MAX_BURST));

   // Gated by reset so that no FIFO is popped while the block is held in reset.
   always_comb begin
      ch_read = '0;
      for (int i = 0; i < NUM_CH; i++)
         ch_read[i] = pop & (g == CH_W'(i)) & ~reset;
   end

   always_ff @(posedge clk160 or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= CH_W'(NUM_CH-1);
         g         <= '0;
         bc        <= '0;
         busy      <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         // Output register: load on pop, otherwise empty it once accepted.
         if (pop) begin
            out_data  <= sel_data;
            out_ch    <= g;
            out_valid <= 1'b1;
            out_last  <= last_beat | data_tran_stop;
            bc        <= bc_inc[7:0];
         end else if (slot_free) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end

         case (state)
            IDLE: begin
               // Stop has priority over a pending grant.
               if (!data_tran_stop && gnt_vld) begin
                  g     <= gnt_idx;
                  bc    <= '0;
                  busy  <= 1'b1;
                  state <= BURST;
               end
            end
            BURST: begin
               if ((pop && last_beat) || data_tran_stop || !sel_ok ||
                   (slot_free && sel_empty)) begin
                  ptr   <= g;
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (slot_free) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Count words on the transfer handshake, not on the pop. A word still
   // in the output register at reset is therefore never counted.
   always_ff @(posedge clk160 or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (out_valid && out_ready) begin
         for (int i = 0; i < NUM_CH; i++)
            if (out_ch == CH_W'(i)) cnt[i] <= cnt[i] + STAT_W'(1);
      end
   end

   assign word_count = cnt;

endmodule

// File: tb/tb_tds_channel_readout_merger.sv
// Scoreboard bench for tds_channel_readout_merger. Per-channel FIFOs are
// modelled in the bench. Expected output words are queued as the stimulus
// is loaded and compared when the DUT transfers them.
module tb_tds_channel_readout_merger;
   import tds_readout_pkg::*;

   localparam int NCH = 4, DW = 120, CW = 4, MB = 16, SW = 32, DEPTH = 64;

   logic                 clk160 = 1'b0, reset = 1'b1;
   logic [NCH-1:0]       enable = '1, strip_linked = '1, pad_linked = '1;
   logic                 tds_mode = 1'b1, data_tran_stop = 1'b0, out_ready = 1'b1;
   logic [NCH-1:0]       channel_linked, ch_empty = '1, ch_read;
   logic [NCH*DW-1:0]    ch_data = '0;
   logic [DW-1:0]        out_data;
   logic [CW-1:0]        out_ch;
   logic                 out_last, out_valid, busy;
   logic [NCH*SW-1:0]    word_count;

   tds_channel_readout_merger #(.NUM_CH(NCH), .DATA_W(DW), .CH_W(CW),
                                .MAX_BURST(MB), .STAT_W(SW)) dut (
      .clk160(clk160), .reset(reset), .enable(enable), .tds_mode(tds_mode),
      .strip_linked(strip_linked), .pad_linked(pad_linked),
      .channel_linked(channel_linked), .data_tran_stop(data_tran_stop),
      .ch_data(ch_data), .ch_empty(ch_empty), .ch_read(ch_read),
      .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
      .word_count(word_count)
   );

   always #5 clk160 = ~clk160;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [CW-1:0] ch;
      logic          last;
   } exp_t;

   exp_t            sb[$];
   logic [DW-1:0]   mem [NCH][DEPTH];
   int              head [NCH], tail [NCH], pops [NCH];
   int              n_chk = 0, n_fail = 0, multi_rd = 0;
   bit              rdy_toggle = 0, stop_arm = 0, busy_seen = 0, held = 0;
   logic [DW-1:0]   held_d;
   logic [NCH-1:0]  rd_s;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      n_chk++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [DW-1:0] word(input int ch, input int seq);
      logic [DW-1:0] w;
      w = '0;
      w[15:0]      = 16'(seq);
      w[19:16]     = 4'(ch);
      w[DW-1 -: 8] = 8'(seq * 7 + ch + 1);
      return w;
   endfunction

   task automatic refresh();
      for (int i = 0; i < NCH; i++) begin
         ch_empty[i] = (head[i] == tail[i]);
         ch_data[i*DW +: DW] = (head[i] == tail[i]) ? '0 : mem[i][head[i]];
      end
   endtask

   task automatic load(input int ch, input int n);
      for (int k = 0; k < n; k++) begin
         mem[ch][tail[ch]] = word(ch, tail[ch]);
         tail[ch]++;
      end
      refresh();
   endtask

   task automatic expect_run(input int ch, input int first, input int n, input int last_at);
      for (int k = 0; k < n; k++)
         sb.push_back('{word(ch, first + k), CW'(ch), (k == last_at)});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      out_ready = 1'b1; data_tran_stop = 1'b0; stop_arm = 0; rdy_toggle = 0;
      for (int i = 0; i < NCH; i++) begin head[i] = 0; tail[i] = 0; pops[i] = 0; end
      sb.delete(); multi_rd = 0; busy_seen = 0; held = 0;
      refresh();
      repeat (2) @(negedge clk160);
      reset = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      bit done = 0;
      for (int c = 0; c < 1000 && !done; c++) begin
         @(negedge clk160);
         if (sb.size() == 0 && !busy) done = 1;
      end
      chk(tag, 128'(done), 128'(1));
   endtask

   // FIFO model: ch_read is sampled at the edge. The FIFO heads are then
   // updated 1 time unit later, clear of the DUT's own sampling of them.
   always @(posedge clk160) begin
      rd_s = ch_read;
      if ($countones(rd_s) > 1) multi_rd++;
      if (busy) busy_seen = 1;
      for (int i = 0; i < NCH; i++)
         if (rd_s[i]) begin
            if (head[i] < tail[i]) head[i]++;
            pops[i]++;
         end
      #1;
      refresh();
      if (stop_arm && (pops[0] + pops[1] + pops[2] + pops[3]) == 4) begin
         data_tran_stop = 1'b1;
         stop_arm = 0;
      end
      out_ready = rdy_toggle ? ~out_ready : 1'b1;
   end

   // Output monitor and scoreboard compare.
   always @(negedge clk160) begin
      exp_t e;
      if (!reset) begin
         if (held && out_valid) chk("stall_hold", 128'(out_data), 128'(held_d));
         held   = out_valid && !out_ready;
         held_d = out_data;
         if (out_valid && out_ready) begin
            chk("sb_pending", 128'(sb.size() > 0), 128'(1));
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("sb_data", 128'(out_data), 128'(e.d));
               chk("sb_ch",   128'(out_ch),   128'(e.ch));
               chk("sb_last", 128'(out_last), 128'(e.last));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      for (int i = 0; i < NCH; i++) begin head[i] = 0; tail[i] = 0; pops[i] = 0; end
      refresh();
      #12;
      chk("rst_valid", 128'(out_valid), 128'(0));
      chk("rst_data",  128'(out_data),  128'(0));
      chk("rst_busy",  128'(busy),      128'(0));
      chk("rst_cnt",   128'(word_count), 128'(0));
      chk("rst_read",  128'(ch_read),   128'(0));
      do_reset();

      // 20 words on ch0: a 16-word burst closed by out_last, then a 4-word re-grant.
      load(0, 20);
      expect_run(0, 0, 16, 15);
      expect_run(0, 16, 4, -1);
      wait_idle("t1_done");
      chk("t1_cnt0", 128'(word_count[0*SW +: SW]), 128'(20));

      // Three words per channel, served in round-robin order.
      do_reset();
      for (int c = 0; c < NCH; c++) load(c, 3);
      for (int c = 0; c < NCH; c++) expect_run(c, 0, 3, -1);
      wait_idle("t2_done");
      chk("t2_onehot", 128'(multi_rd), 128'(0));
      for (int c = 0; c < NCH; c++) chk("t2_cnt", 128'(word_count[c*SW +: SW]), 128'(3));

      // Backpressure toggling every cycle during a 10-word burst.
      do_reset();
      rdy_toggle = 1;
      load(2, 10);
      expect_run(2, 0, 10, -1);
      wait_idle("t3_done");
      rdy_toggle = 0;
      chk("t3_pops", 128'(pops[2]), 128'(10));
      chk("t3_cnt2", 128'(word_count[2*SW +: SW]), 128'(10));

      // A disabled channel is never granted; pad mode with pads unlinked grants nothing.
      do_reset();
      enable = 4'b1101;
      load(1, 3);
      load(0, 2);
      expect_run(0, 0, 2, -1);
      wait_idle("t4_done");
      chk("t4_ch1_pops", 128'(pops[1]), 128'(0));
      enable = '1; tds_mode = 1'b0; pad_linked = '0; busy_seen = 0;
      repeat (20) @(negedge clk160);
      chk("t4_pad_busy", 128'(busy_seen), 128'(0));
      chk("t4_pad_pops", 128'(pops[1]), 128'(0));
      chk("t4_linked",   128'(channel_linked), 128'(0));
      do_reset();
      tds_mode = 1'b1; pad_linked = '1;

      // Stop asserted during the 5th pop.
      do_reset();
      load(0, 10);
      expect_run(0, 0, 5, 4);
      stop_arm = 1;
      got = 0;
      for (int c = 0; c < 100 && !got; c++) begin
         @(negedge clk160);
         if (pops[0] >= 5) got = 1;
      end
      chk("t5_reach5", 128'(got), 128'(1));
      repeat (10) @(negedge clk160);
      chk("t5_pops_held", 128'(pops[0]), 128'(5));
      chk("t5_idle", 128'(busy), 128'(0));
      chk("t5_sb_empty", 128'(sb.size()), 128'(0));
      data_tran_stop = 1'b0;
      expect_run(0, 5, 5, -1);
      wait_idle("t5_done");
      chk("t5_pops", 128'(pops[0]), 128'(10));

      // Reset in the middle of a burst, then arbitration restarts at ch0.
      do_reset();
      load(0, 10);
      expect_run(0, 0, 10, -1);
      got = 0;
      for (int c = 0; c < 100 && !got; c++) begin
         @(negedge clk160);
         if (pops[0] >= 3) got = 1;
      end
      chk("t6_reach3", 128'(got), 128'(1));
      @(posedge clk160);
      #2;
      chk("t6_pre_valid", 128'(out_valid), 128'(1));
      reset = 1'b1;
      #1;
      chk("t6_rst_valid", 128'(out_valid), 128'(0));
      chk("t6_rst_cnt",   128'(word_count), 128'(0));
      chk("t6_rst_read",  128'(ch_read), 128'(0));
      do_reset();
      load(1, 2);
      load(0, 2);
      expect_run(0, 0, 2, -1);
      expect_run(1, 0, 2, -1);
      wait_idle("t6_done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
